// File: rtl/rat_port_fifo.sv
// Port-mapped 8-bit FIFO responder on the RAT MCU I/O bus.
// Optional interrupt on first push into an empty FIFO: define RAT_FIFO_INT_EN.
module rat_port_fifo #(
  parameter logic [7:0] BASE_PORT = 8'h30,
  parameter int         DEPTH     = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       SEL,
  output logic       INT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          unf;
  logic          int_en;
  logic [7:0]    off;
  logic          full;
  logic          empty;
  logic          wr_data;
  logic          wr_cmd;

  assign off     = PORT_ID - BASE_PORT;
  assign SEL     = (off[7:2] == 6'd0);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_data = IO_STRB && SEL && (off[1:0] == 2'd0);
  assign wr_cmd  = IO_STRB && SEL && (off[1:0] == 2'd2);

  always_ff @(posedge CLK) begin
    if (!RST && wr_data && !full) mem[wr_ptr] <= OUT_PORT;
  end

  // flush outranks pop; the clear bit lands last so it beats a fresh underflow
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (wr_data) begin
      if (full) begin
        ovf <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end
    end else if (wr_cmd) begin
      if (OUT_PORT[1]) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (OUT_PORT[0]) begin
        if (empty) begin
          unf <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
          count  <= count - CW'(1);
        end
      end
      if (OUT_PORT[2]) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
    end
  end

`ifdef RAT_FIFO_INT_EN
  logic int_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      int_en <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      int_q <= wr_data && empty && int_en;
      if (wr_cmd && OUT_PORT[7]) int_en <= OUT_PORT[4];
    end
  end

  assign INT = int_q;
`else
  assign int_en = 1'b0;
  assign INT    = 1'b0;
`endif

  always_comb begin
    IN_PORT = 8'h00;
    if (SEL) begin
      unique case (off[1:0])
        2'd0: IN_PORT = empty ? 8'h00 : mem[rd_ptr];
        2'd1: IN_PORT = {3'b000, int_en, unf, ovf, full, empty};
        2'd2: IN_PORT = 8'h00;
        2'd3: IN_PORT = 8'(count);
      endcase
    end
  end

endmodule

// File: tb/tb_rat_port_fifo.sv
// Bench for rat_port_fifo: queue model compared every cycle,
// plus literal expectations at key points.
module tb_rat_port_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] PORT_ID = 8'h00;
  logic [7:0] OUT_PORT = 8'h00;
  logic       IO_STRB = 1'b0;
  logic [7:0] IN_PORT;
  logic       SEL;
  logic       INT;

  rat_port_fifo #(.BASE_PORT(8'h30), .DEPTH(16)) dut (
    .CLK(CLK), .RST(RST), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .SEL(SEL), .INT(INT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];
  bit ovf_m, unf_m, ie_m, int_m;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_in(input logic [7:0] pid);
    logic [7:0] r;
    r = 8'h00;
    case (pid)
      8'h30: r = (q.size() == 0) ? 8'h00 : q[0];
      8'h31: r = {3'b000, ie_m, unf_m, ovf_m,
                  q.size() == 16, q.size() == 0};
      8'h33: r = 8'(q.size());
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic apply(input logic r, input logic [7:0] pid,
                       input logic [7:0] d, input logic s);
    int_m = 1'b0;
    if (r) begin
      q.delete();
      ovf_m = 0;
      unf_m = 0;
      ie_m = 0;
    end else if (s && pid == 8'h30) begin
      if (q.size() == 16) ovf_m = 1;
      else begin
`ifdef RAT_FIFO_INT_EN
        if (q.size() == 0 && ie_m) int_m = 1'b1;
`endif
        q.push_back(d);
      end
    end else if (s && pid == 8'h32) begin
      if (d[1]) q.delete();
      else if (d[0]) begin
        if (q.size() == 0) unf_m = 1;
        else void'(q.pop_front());
      end
      if (d[2]) begin
        ovf_m = 0;
        unf_m = 0;
      end
`ifdef RAT_FIFO_INT_EN
      if (d[7]) ie_m = d[4];
`endif
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("in_port", IN_PORT, exp_in(PORT_ID));
      check("sel", {7'b0, SEL}, {7'b0, PORT_ID >= 8'h30 && PORT_ID <= 8'h33});
      check("int", {7'b0, INT}, {7'b0, int_m});
    end
  end

  task automatic step(input logic [7:0] pid, input logic [7:0] d,
                      input logic s, input logic r);
    RST = r;
    PORT_ID = pid;
    OUT_PORT = d;
    IO_STRB = s;
    @(posedge CLK);
    apply(r, pid, d, s);
    #1;
    IO_STRB = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    step(8'h30, d, 1'b1, 1'b0);
  endtask

  task automatic cmd(input logic [7:0] d);
    step(8'h32, d, 1'b1, 1'b0);
  endtask

  task automatic lit(input string name, input logic [7:0] pid,
                     input logic [7:0] exp);
    PORT_ID = pid;
    IO_STRB = 1'b0;
    #1;
    check(name, IN_PORT, exp);
  endtask

  task automatic lit_int(input string name, input logic exp);
    #1;
    check(name, {7'b0, INT}, {7'b0, exp});
  endtask

  logic [7:0] sel_ids [6] = '{8'h2F, 8'h30, 8'h33, 8'h34, 8'h00, 8'hFF};
  logic       sel_exp [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    step(8'h00, 8'h00, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(8'h30, 8'h77, 1'b1, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b0);

    lit("rst_status", 8'h31, 8'h01);
    lit("rst_count", 8'h33, 8'h00);
    lit("rst_data", 8'h30, 8'h00);
    lit_int("rst_int", 1'b0);
    for (int i = 0; i < 6; i++) begin
      PORT_ID = sel_ids[i];
      #1;
      check("sel_decode", {7'b0, SEL}, {7'b0, sel_exp[i]});
      check("unsel_zero", IN_PORT, sel_exp[i] ? IN_PORT : 8'h00);
    end

    push(8'hA5);
    push(8'h3C);
    lit("count2", 8'h33, 8'h02);
    lit("head_a5", 8'h30, 8'hA5);
    cmd(8'h01);
    lit("head_3c", 8'h30, 8'h3C);
    cmd(8'h01);
    lit("empty_again", 8'h31, 8'h01);

    for (int i = 0; i < 17; i++) push(8'(i));
    lit("full_ovf", 8'h31, 8'h06);
    lit("count16", 8'h33, 8'h10);
    step(8'h31, 8'hFF, 1'b1, 1'b0);
    step(8'h33, 8'hFF, 1'b1, 1'b0);
    lit("ro_ports", 8'h33, 8'h10);
    for (int i = 0; i < 16; i++) begin
      lit("wrap_order", 8'h30, 8'(i));
      cmd(8'h01);
    end
    lit("drained", 8'h33, 8'h00);
    lit("no_17th", 8'h30, 8'h00);

    cmd(8'h01);
    lit("underflow", 8'h31, 8'h0D);
    cmd(8'h04);
    lit("clear_flags", 8'h31, 8'h01);
    cmd(8'h05);
    lit("pop_clr_empty", 8'h31, 8'h01);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    cmd(8'h03);
    lit("flush_count", 8'h33, 8'h00);
    lit("flush_status", 8'h31, 8'h01);

`ifdef RAT_FIFO_INT_EN
    cmd(8'h90);
    lit("int_en_set", 8'h31, 8'h11);
    push(8'h11);
    lit_int("int_pulse", 1'b1);
    step(8'h31, 8'h00, 1'b0, 1'b0);
    lit_int("int_one_cycle", 1'b0);
    push(8'h22);
    lit_int("int_second_push", 1'b0);
    cmd(8'h82);
    lit("int_en_clr", 8'h31, 8'h01);
    push(8'h33);
    lit_int("int_disabled", 1'b0);
    cmd(8'h92);
    for (int i = 0; i < 16; i++) push(8'(i));
    cmd(8'h01);
    cmd(8'h02);
`else
    cmd(8'h90);
    lit("no_int_en", 8'h31, 8'h01);
    push(8'h11);
    lit_int("int_tied", 1'b0);
    step(8'h31, 8'h00, 1'b0, 1'b0);
    lit_int("int_tied2", 1'b0);
    cmd(8'h02);
`endif

    push(8'hD0);
    push(8'hD1);
    step(8'h30, 8'hD2, 1'b1, 1'b1);
    push(8'hD3);
    push(8'hD4);
    lit("post_rst_count", 8'h33, 8'h02);
    lit("post_rst_head", 8'h30, 8'hD3);
    step(8'h30, 8'hEE, 1'b1, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b0);
    lit("rst_mid_count", 8'h33, 8'h00);
    lit("rst_mid_status", 8'h31, 8'h01);
    step(8'h30, 8'h00, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
